stream_demux: RTL and testbench

- Registered 1-to-N stream demultiplexer: routes WIDTH-bit words from one input stream to one of CHANNELS output streams, or to all of them.
- Each output has a one-entry holding register with a valid/ready handshake, so back-pressure on one channel does not block traffic to the others.
- Sits between a single producer (switch/UART/data source) and multiple consumers (display drivers, register banks).
- Generalises the fixed 4-way 8-bit combinational demux with width/channel parameters, Enable gating, broadcast mode and flow control.

---
 rtl/stream_demux.sv | 81 ++++++++
 tb/tb_stream_demux.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N stream demultiplexer.
// Each output channel owns a one-entry holding slot with a valid/ready
// handshake, so a stalled consumer only blocks words aimed at its own slot.
// In broadcast mode one word is written to every slot at once. That needs
// all slots free in the same cycle, so every lane sees the same word.
module stream_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          data,
  input  logic [SEL_W-1:0]          Sel,
  input  logic                      Broadcast,
  input  logic                      Enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH*CHANNELS-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [7:0]                drop_count
);

  logic [CHANNELS-1:0] slot_free;
  logic [CHANNELS-1:0] load;
  logic                accept;

  // A slot can take a word if it is empty or is being drained this very cycle.
  always_comb begin
    slot_free = ~out_valid | out_ready;
  end

  // The input is accepted only when enabled, out of reset and every targeted slot is free.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && Enable) begin
      if (Broadcast) begin
        in_ready = &slot_free;
      end else begin
        in_ready = slot_free[Sel];
      end
    end
  end

  // Decode which slots take the incoming word on this edge.
  always_comb begin
    accept = in_valid & in_ready;
    load   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      load[k] = accept & (Broadcast | (Sel == SEL_W'(k)));
    end
  end

  // Per-slot EMPTY/FULL state and data: a reload wins over a drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (load[k]) begin
          out_data[k*WIDTH +: WIDTH] <= data;
          out_valid[k]               <= 1'b1;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Count words offered while disabled. The count saturates at 255 instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= 8'd0;
    end else if (in_valid && !Enable && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed-vector bench for stream_demux (WIDTH=8, CHANNELS=4).
// Expected values are written out by hand next to each vector.
module tb_stream_demux;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic [1:0]  Sel;
  logic        Broadcast;
  logic        Enable;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  drop_count;

  int compareCount  = 0;
  int mismatchCount = 0;

  stream_demux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .Sel        (Sel),
    .Broadcast  (Broadcast),
    .Enable     (Enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_count (drop_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point; counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive the producer/consumer inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic vld, input logic [1:0] sel, input logic bc,
                               input logic en, input logic [7:0] d, input logic [3:0] ordy);
    in_valid  = vld;
    Sel       = sel;
    Broadcast = bc;
    Enable    = en;
    data      = d;
    out_ready = ordy;
    #1;
  endtask

  // Advance one clock edge and sample 1 ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 8'h00, 4'b0000);

    // Reset held for two edges with traffic offered.
    tick();
    tick();
    checkOutput("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {28'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data",  out_data, 32'd0);
    checkOutput("rst_drop",      {24'd0, drop_count}, 32'd0);

    // Basic routing to channel 2.
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 4'b1111);
    tick();
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 8'hA5, 4'b1111);
    checkOutput("route_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 4'b1111);
    checkOutput("route_valid", {28'd0, out_valid}, 32'h4);
    checkOutput("route_data",  out_data, 32'h00A5_0000);
    tick();
    checkOutput("route_drain", {28'd0, out_valid}, 32'h0);

    // Back-pressure on channel 1.
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 8'h11, 4'b1101);
    checkOutput("bp_first_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("bp_first_valid", {28'd0, out_valid}, 32'h2);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 8'h22, 4'b1101);
    checkOutput("bp_stall_ready", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("bp_hold_data",  out_data, 32'h00A5_1100);
    checkOutput("bp_hold_valid", {28'd0, out_valid}, 32'h2);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 8'h22, 4'b1111);
    checkOutput("bp_refill_ready", {31'd0, in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 4'b0101);
    checkOutput("bp_refill_valid", {28'd0, out_valid}, 32'h2);
    checkOutput("bp_refill_data",  out_data, 32'h00A5_2200);

    // Independence: channel 1 stays stalled while channel 3 loads.
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, 8'h33, 4'b0101);
    checkOutput("ind_ready", {31'd0, in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1, 8'hEE, 4'b0101);
    checkOutput("ind_valid", {28'd0, out_valid}, 32'hA);
    checkOutput("ind_data",  out_data, 32'h33A5_2200);

    // Sel/data changes without an accept leave the slots alone.
    tick();
    checkOutput("noacc_data", out_data, 32'h33A5_2200);

    // Broadcast into all-empty slots.
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 4'b1111);
    tick();
    checkOutput("bc_empty_valid", {28'd0, out_valid}, 32'h0);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b1, 8'h5A, 4'b1111);
    checkOutput("bc_ready", {31'd0, in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 4'b1111);
    checkOutput("bc_valid", {28'd0, out_valid}, 32'hF);
    checkOutput("bc_data",  out_data, 32'h5A5A_5A5A);
    tick();

    // Broadcast blocked by a stalled channel 0.
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 8'h77, 4'b1110);
    tick();
    checkOutput("bc_ch0_valid", {28'd0, out_valid}, 32'h1);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b1, 8'hC3, 4'b1110);
    checkOutput("bc_block_ready", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("bc_block_valid", {28'd0, out_valid}, 32'h1);
    checkOutput("bc_block_data",  out_data, 32'h5A5A_5A77);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b1, 8'hC3, 4'b1111);
    checkOutput("bc_unblock_ready", {31'd0, in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 4'b1111);
    checkOutput("bc_unblock_valid", {28'd0, out_valid}, 32'hF);
    checkOutput("bc_unblock_data",  out_data, 32'hC3C3_C3C3);
    checkOutput("stall_not_dropped", {24'd0, drop_count}, 32'd0);

    // Enable low: words dropped, counter saturates at 255.
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 8'h99, 4'b1111);
    checkOutput("dis_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 1)   checkOutput("drop_1",   {24'd0, drop_count}, 32'd1);
      if (i == 254) checkOutput("drop_254", {24'd0, drop_count}, 32'd254);
      if (i == 255) checkOutput("drop_255", {24'd0, drop_count}, 32'd255);
    end
    checkOutput("drop_sat",      {24'd0, drop_count}, 32'd255);
    checkOutput("dis_no_load",   {28'd0, out_valid}, 32'h0);
    checkOutput("dis_data_kept", out_data, 32'hC3C3_C3C3);

    // Reset pulse clears the drop counter and the data lanes.
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("rst2_drop", {24'd0, drop_count}, 32'd0);
    checkOutput("rst2_data", out_data, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 4'b1111);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
